// File: rtl/elements_seq_if.sv
// rtl/elements_seq_if.sv - request/result handshake bundle for elements_seq
interface elements_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a3;
    logic [3:0]  b3;
    logic [3:0]  c3;
    logic [7:0]  a4;
    logic [7:0]  b4;
    logic [7:0]  c4;
    logic        as;
    logic        bs;
    logic        cs;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_mag;
    logic        out_sign;
    logic        busy;

    modport master (
        output in_valid, a3, b3, c3, a4, b4, c4, as, bs, cs, out_ready,
        input  in_ready, out_valid, out_mag, out_sign, busy
    );

    modport slave (
        input  in_valid, a3, b3, c3, a4, b4, c4, as, bs, cs, out_ready,
        output in_ready, out_valid, out_mag, out_sign, busy
    );
endinterface

// File: rtl/elements_seq.sv
// rtl/elements_seq.sv - three-term signed multiply-accumulate sharing one 8x4 multiplier
module elements_seq (
    input logic           clk,
    input logic           rst,
    elements_seq_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] T0   = 3'd1;
    localparam logic [2:0] T1   = 3'd2;
    localparam logic [2:0] T2   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state;
    logic [3:0]  a3_r, b3_r, c3_r;
    logic [7:0]  a4_r, b4_r, c4_r;
    logic        as_r, bs_r, cs_r;
    logic [14:0] acc_mag;
    logic        acc_sign;
    logic [14:0] mag_r;
    logic        sign_r;
    logic        valid_r;

    logic [7:0]  mul_x;
    logic [3:0]  mul_y;
    logic        prod_sign;
    logic [11:0] prod;
    logic [14:0] prod15;
    logic [14:0] sum_mag;
    logic        sum_sign;

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_x     = a4_r;
        mul_y     = a3_r;
        prod_sign = as_r;
        case (state)
            T1: begin
                mul_x     = b4_r;
                mul_y     = b3_r;
                prod_sign = bs_r;
            end
            T2: begin
                mul_x     = c4_r;
                mul_y     = c3_r;
                prod_sign = cs_r;
            end
            default: ;
        endcase
    end

    assign prod   = {4'd0, mul_x} * {8'd0, mul_y};
    assign prod15 = {3'd0, prod};

    // Sign-magnitude add; a zero product or exact cancellation never yields -0.
    always_comb begin
        sum_mag  = acc_mag;
        sum_sign = acc_sign;
        if (prod15 != 15'd0) begin
            if (prod_sign == acc_sign) begin
                sum_mag  = acc_mag + prod15;
                sum_sign = acc_sign;
            end else if (acc_mag > prod15) begin
                sum_mag  = acc_mag - prod15;
                sum_sign = acc_sign;
            end else if (prod15 > acc_mag) begin
                sum_mag  = prod15 - acc_mag;
                sum_sign = prod_sign;
            end else begin
                sum_mag  = 15'd0;
                sum_sign = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a3_r     <= 4'd0;
            b3_r     <= 4'd0;
            c3_r     <= 4'd0;
            a4_r     <= 8'd0;
            b4_r     <= 8'd0;
            c4_r     <= 8'd0;
            as_r     <= 1'b0;
            bs_r     <= 1'b0;
            cs_r     <= 1'b0;
            acc_mag  <= 15'd0;
            acc_sign <= 1'b0;
            mag_r    <= 15'd0;
            sign_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.in_valid) begin
                        a3_r     <= bus.a3;
                        b3_r     <= bus.b3;
                        c3_r     <= bus.c3;
                        a4_r     <= bus.a4;
                        b4_r     <= bus.b4;
                        c4_r     <= bus.c4;
                        as_r     <= bus.as;
                        bs_r     <= bus.bs;
                        cs_r     <= bus.cs;
                        acc_mag  <= 15'd0;
                        acc_sign <= 1'b0;
                        state    <= T0;
                    end
                end
                T0: begin
                    acc_mag  <= sum_mag;
                    acc_sign <= sum_sign;
                    state    <= T1;
                end
                T1: begin
                    acc_mag  <= sum_mag;
                    acc_sign <= sum_sign;
                    state    <= T2;
                end
                T2: begin
                    acc_mag  <= sum_mag;
                    acc_sign <= sum_sign;
                    mag_r    <= sum_mag;
                    sign_r   <= sum_sign;
                    state    <= DONE;
                end
                DONE: begin
                    // Result is presented one cycle after entering DONE and held until taken.
                    if (valid_r && bus.out_ready) begin
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = valid_r;
    assign bus.out_mag   = mag_r;
    assign bus.out_sign  = sign_r;
endmodule

// File: tb/tb_elements_seq.sv
// tb/tb_elements_seq.sv - scoreboard bench for elements_seq
module tb_elements_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [15:0] sb[$];

    elements_seq_if bus ();

    elements_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(
        input int xa4, input int xa3, input logic xas,
        input int xb4, input int xb3, input logic xbs,
        input int xc4, input int xc3, input logic xcs);
        int r;
        int m;
        logic [14:0] m15;
        r = (xas ? -1 : 1) * xa4 * xa3 + (xbs ? -1 : 1) * xb4 * xb3 + (xcs ? -1 : 1) * xc4 * xc3;
        m = (r < 0) ? -r : r;
        m15 = m[14:0];
        return {(r < 0), m15};
    endfunction

    task automatic send(
        input logic [7:0] xa4, input logic [3:0] xa3, input logic xas,
        input logic [7:0] xb4, input logic [3:0] xb3, input logic xbs,
        input logic [7:0] xc4, input logic [3:0] xc3, input logic xcs);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_ready: in_ready=%0b required 1", bus.in_ready);
        end
        bus.a4 = xa4; bus.a3 = xa3; bus.as = xas;
        bus.b4 = xb4; bus.b3 = xb3; bus.bs = xbs;
        bus.c4 = xc4; bus.c3 = xc3; bus.cs = xcs;
        bus.in_valid = 1'b1;
        sb.push_back(model(int'(xa4), int'(xa3), xas, int'(xb4), int'(xb3), xbs,
                           int'(xc4), int'(xc3), xcs));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_sign, bus.out_mag} !== {3'b100, 16'd0}) begin
            errors++;
            $display("FAIL reset_state: rdy/vld/busy/sign/mag=%b required 100 0 0",
                     {bus.in_ready, bus.out_valid, bus.busy, bus.out_sign, bus.out_mag});
        end
    endtask

    task automatic test_positive;
        int n;
        logic [15:0] exp;
        bus.out_ready = 1'b1;
        send(8'd10, 4'd3, 1'b0, 8'd5, 4'd2, 1'b0, 8'd1, 4'd1, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL positive_busy: busy=%b in_ready=%b required 1 0", bus.busy, bus.in_ready);
        end
        wait_valid(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL positive_latency: edges=%0d required 4", n);
        end
        exp = sb.pop_front();
        checks++;
        if ({bus.out_sign, bus.out_mag} !== exp || exp !== {1'b0, 15'd41}) begin
            errors++;
            $display("FAIL positive_result: got %0b/%0d required %0b/%0d",
                     bus.out_sign, bus.out_mag, exp[15], exp[14:0]);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL positive_pulse: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_mixed;
        int n;
        logic [15:0] exp;
        send(8'd20, 4'd5, 1'b0, 8'd15, 4'd7, 1'b1, 8'd0, 4'd9, 1'b0);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n >= 20 || {bus.out_sign, bus.out_mag} !== exp || exp !== {1'b1, 15'd5}) begin
            errors++;
            $display("FAIL mixed_result: got %0b/%0d required %0b/%0d", bus.out_sign, bus.out_mag, exp[15], exp[14:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_cancel;
        int n;
        logic [15:0] exp;
        send(8'd12, 4'd4, 1'b0, 8'd6, 4'd8, 1'b1, 8'd0, 4'd0, 1'b1);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n >= 20 || {bus.out_sign, bus.out_mag} !== exp || exp !== 16'd0) begin
            errors++;
            $display("FAIL cancel_result: got %0b/%0d required %0b/%0d", bus.out_sign, bus.out_mag, exp[15], exp[14:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_extremes;
        int n;
        logic [15:0] exp;
        for (int s = 0; s < 2; s++) begin
            send(8'd255, 4'd15, s[0], 8'd255, 4'd15, s[0], 8'd255, 4'd15, s[0]);
            wait_valid(n);
            exp = sb.pop_front();
            checks++;
            if (n >= 20 || {bus.out_sign, bus.out_mag} !== exp || exp[14:0] !== 15'd11475) begin
                errors++;
                $display("FAIL extreme_%0d: got %0b/%0d required %0b/%0d", s, bus.out_sign, bus.out_mag, exp[15], exp[14:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int n;
        logic [15:0] exp;
        bus.out_ready = 1'b0;
        send(8'd7, 4'd3, 1'b1, 8'd2, 4'd2, 1'b0, 8'd9, 4'd1, 1'b1);
        wait_valid(n);
        exp = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.a4 = 8'd99; bus.a3 = 4'd9; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            checks++;
            if (n >= 20 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.out_sign, bus.out_mag} !== exp) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: vld=%b rdy=%b got %0b/%0d required 1 0 %0b/%0d",
                         i, bus.out_valid, bus.in_ready, bus.out_sign, bus.out_mag, exp[15], exp[14:0]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: vld=%b rdy=%b busy=%b required 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_accept: vld=%b busy=%b required 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        logic [15:0] exp;
        bus.out_ready = 1'b1;
        send(8'd50, 4'd6, 1'b0, 8'd3, 4'd3, 1'b0, 8'd1, 4'd2, 1'b1);
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_mag !== 15'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: rdy=%b vld=%b mag=%0d busy=%b required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_mag, bus.busy);
        end
        send(8'd4, 4'd4, 1'b1, 8'd1, 4'd1, 1'b0, 8'd2, 4'd3, 1'b0);
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if (n != 4 || {bus.out_sign, bus.out_mag} !== exp) begin
            errors++;
            $display("FAIL reset_mid_fresh: n=%0d got %0b/%0d required 4 %0b/%0d", n, bus.out_sign, bus.out_mag, exp[15], exp[14:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_vs_valid;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wins: busy=%b in_ready=%b required 0 1", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [15:0] exp;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            wait_valid(n);
            exp = sb.pop_front();
            checks++;
            if (n != 4 || {bus.out_sign, bus.out_mag} !== exp) begin
                errors++;
                $display("FAIL back_to_back_%0d: n=%0d got %0b/%0d required 4 %0b/%0d",
                         i, n, bus.out_sign, bus.out_mag, exp[15], exp[14:0]);
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a4 = 8'd0; bus.a3 = 4'd0; bus.as = 1'b0;
        bus.b4 = 8'd0; bus.b3 = 4'd0; bus.bs = 1'b0;
        bus.c4 = 8'd0; bus.c3 = 4'd0; bus.cs = 1'b0;
        @(negedge clk);
        test_reset();
        test_positive();
        test_mixed();
        test_cancel();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_rst_vs_valid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/elements_seq.md
ELEMENTS_SEQ -- requirements
Module: elements_seq

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 in_valid  input  1  request valid; operands below are stable while it is high.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a3, b3, c3  input  4 each  unsigned 4-bit multiplier magnitudes.
REQ-007 a4, b4, c4  input  8 each  unsigned 8-bit multiplicand magnitudes.
REQ-008 as, bs, cs  input  1 each  term signs; 1 = negative.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_mag  output  15  result magnitude.
REQ-012 out_sign  output  1  result sign; 1 = negative.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block shall compute R = (as? -1:+1)*a4*a3 + (bs? -1:+1)*b4*b3 + (cs? -1:+1)*c4*c3 in sign-magnitude form.
REQ-015 The block shall contain exactly one 8x4 unsigned multiplier and one 15-bit sign-magnitude adder/subtractor, time-shared across the three terms.
REQ-016 FSM states: IDLE, T0, T1, T2, DONE.
REQ-017 in_ready shall be 1 only in IDLE; an accept occurs when in_valid and in_ready are both 1 at a clock edge.
REQ-018 On accept, all 39 operand bits shall be registered, the accumulator shall be cleared to +0, and the state shall move IDLE->T0.
REQ-019 T0/T1/T2 shall each last one cycle, multiplying the a/b/c operand pair respectively and adding the signed product into the accumulator at the end of that cycle; transitions T0->T1->T2->DONE.
REQ-020 out_valid shall be 1 exactly in DONE, first asserted in the cycle after the 4th clock edge following the accept edge (accept at edge k, out_valid high after edge k+4).
REQ-021 In DONE, out_mag/out_sign shall hold constant until out_valid and out_ready are both 1 at an edge; the state then returns to IDLE, and out_valid drops in the following cycle.
REQ-022 in_valid shall be ignored in all states except IDLE; no request queueing.
REQ-023 Accumulation rule: equal signs -> add magnitudes, keep sign; differing signs -> larger magnitude minus smaller, sign of the larger; equal magnitudes -> +0.
REQ-024 A product of magnitude 0 shall leave the accumulator unchanged regardless of its sign bit.
REQ-025 A zero result shall always be reported with out_sign=0; negative zero is never output.
REQ-026 Widths: each product is at most 12 bits (max 3825), and |R| is at most 11475; 15 bits cannot overflow, so no overflow flag exists.
REQ-027 out_mag/out_sign shall retain the last result while outside DONE; they change only in the T0..T2 update path.

Reset
REQ-028 rst=1 at an edge shall force IDLE from any state, including T0..T2 and DONE, and discard any in-progress computation.
REQ-029 After reset: in_ready=1, out_valid=0, busy=0, out_mag=0, out_sign=0, accumulator=+0, operand registers=0.
REQ-030 When rst and in_valid are both 1 at the same edge, the reset shall win and no accept shall occur.

Verification
REQ-031 Three positive terms: a=10*3 (+), b=5*2 (+), c=1*1 (+), out_ready=1 -> out_mag=41, out_sign=0; out_valid rises 4 edges after accept and lasts 1 cycle.
REQ-032 Mixed signs: +20*5, -15*7, +0*9 -> out_mag=5, out_sign=1.
REQ-033 Cancellation: +12*4, -6*8, c=-0*0 -> out_mag=0, out_sign=0; negative zero never appears.
REQ-034 Extremes: all terms 255*15 positive -> 11475/0; all negative -> 11475/1.
REQ-035 Backpressure: out_ready=0 for 5 cycles with a new in_valid pulse -> result held stable, in_ready=0, new request not accepted; out_ready=1 -> IDLE the following cycle.
REQ-036 Reset mid-operation: rst=1 during T1 -> next cycle IDLE, in_ready=1, out_valid=0, out_mag=0; a fresh request then completes correctly.
